// File: rtl/gemm_pkg.sv
// Shared GEMM datapath types: operand packer FSM states and lane-count width.
// Imported by operand_packer; element width and pair count stay per-module parameters.
package gemm_pkg;

    // FILL collects elements, HOLD presents the packed vector downstream.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Width able to hold a lane count in 0..2*num.
    function automatic int lane_cnt_w(input int num);
        return $clog2(2 * num + 1);
    endfunction

endpackage

// File: rtl/operand_packer.sv
// Packs a stream of scalar elements into a 2*NUM lane vector for the adder array.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   scalar element handshake; in_data payload, in_last closes early
//   out_valid/out_ready vector handshake to the adder array stage
//   out_data            lane vector, lanes 2i/2i+1 form adder pair i
//   out_lanes           number of lanes filled from input (1..2*NUM)
module operand_packer
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM        = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [2*NUM-1:0][DATA_WIDTH-1:0]    out_data,
    output logic [lane_cnt_w(NUM)-1:0]          out_lanes
);

    localparam int LANES = 2 * NUM;
    localparam int CW    = lane_cnt_w(NUM);
    localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);
    localparam logic [CW-1:0] ONE_LANE  = CW'(1);

    state_e                           state_q;
    logic                             rdy_en_q;
    logic [LANES-1:0][DATA_WIDTH-1:0] lanes_q;
    logic [CW-1:0]                    cnt_q;

    logic          in_fire;
    logic [IW-1:0] lane_idx;

    // rdy_en_q keeps in_ready low through reset and rises on the first edge after it.
    assign in_ready = rdy_en_q & ((state_q == FILL) | out_ready);
    assign in_fire  = in_valid & in_ready;
    // In FILL the count never reaches LANES, so the low bits are a valid lane index.
    assign lane_idx = cnt_q[IW-1:0];

    assign out_valid = (state_q == HOLD);
    assign out_data  = lanes_q;
    assign out_lanes = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            rdy_en_q <= 1'b0;
            lanes_q  <= '0;
            cnt_q    <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            unique case (state_q)
                FILL: begin
                    if (in_fire) begin
                        lanes_q[lane_idx] <= in_data;
                        cnt_q             <= cnt_q + ONE_LANE;
                        if (in_last || (cnt_q == LAST_LANE)) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        // Unused lanes must read as the additive identity.
                        lanes_q <= '0;
                        if (in_fire) begin
                            lanes_q[0] <= in_data;
                            cnt_q      <= ONE_LANE;
                            state_q    <= in_last ? HOLD : FILL;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= FILL;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/operand_packer.md
OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the element width in bits.
REQ-002 The module SHALL have parameter NUM, default 4, giving the adder-array pair count; the packed vector holds 2*NUM lanes.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the scalar element on in_data is offered.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the packer accepts the offered element this cycle.
REQ-007 The module SHALL have port in_data, input, DATA_WIDTH bits: the scalar element.
REQ-008 The module SHALL have port in_last, input, 1 bit: the accepted element closes the current vector early.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the packed vector is presented.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the downstream adder array stage takes the vector.
REQ-011 The module SHALL have port out_data, output, packed [2*NUM-1:0][DATA_WIDTH-1:0]: the lane vector in the adder-array data_in layout.
REQ-012 The module SHALL have port out_lanes, output, $clog2(2*NUM+1) bits: the count of lanes filled from input (1..2*NUM).

Function
REQ-013 An element SHALL be accepted exactly in cycles where in_valid and in_ready are both 1.
REQ-014 The k-th accepted element of a vector (k = 0..2*NUM-1) SHALL be written to lane k; lane 2i and lane 2i+1 form adder pair i.
REQ-015 The state machine SHALL have exactly two states: FILL (collecting, out_valid=0) and HOLD (vector presented, out_valid=1).
REQ-016 In FILL, in_ready SHALL be 1.
REQ-017 FILL SHALL go to HOLD on the cycle after accepting lane 2*NUM-1, or after accepting any element with in_last=1.
REQ-018 On an early close, lanes above the last written lane SHALL read 0, the additive identity, and out_lanes SHALL equal the number of elements accepted.
REQ-019 In HOLD, out_data and out_lanes SHALL remain stable until out_valid and out_ready are both 1; out_valid SHALL NOT drop before that.
REQ-020 In HOLD, in_ready SHALL equal out_ready, so a new element can be accepted in the same cycle as the output handshake.
REQ-021 An element accepted during that HOLD handshake SHALL become lane 0 of the next vector, and the FSM SHALL go to FILL with a lane count of 1.
REQ-022 If that element also has in_last=1, the FSM SHALL stay in HOLD, presenting a 1-lane vector on the next cycle.
REQ-023 If the HOLD handshake happens without an input handshake, the FSM SHALL go to FILL with all lanes cleared to 0 and the lane count at 0.
REQ-024 Minimum latency SHALL be 1 cycle: out_valid rises the cycle after the closing element is accepted.
REQ-025 At full back-to-back rate with out_ready=1, throughput SHALL be one element per cycle with no bubble.
REQ-026 in_last SHALL be ignored when in_valid is 0; in_data SHALL never be modified arithmetically.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in FILL, with out_valid=0, in_ready=0, out_data all zeros, out_lanes=0 and the lane counter at 0.
REQ-028 Reset asserted mid-vector or in HOLD SHALL discard the partial or held vector, with no output handshake.
REQ-029 in_ready SHALL rise in the first clk cycle after rst_n deasserts.

Structure
REQ-030 A shared package gemm_pkg SHALL hold the FSM state enum (FILL, HOLD) and the lane-count width function; DATA_WIDTH and NUM SHALL remain module parameters.
REQ-031 The module SHALL be a single flat module with no sub-module; its out_data SHALL connect directly to an AdderArray data_in with matching DATA_WIDTH and NUM.

Verification
REQ-032 Full vector: NUM=4, feed 1..8 with in_valid held high and out_ready=1 -> out_valid one cycle after 8, with out_data lanes 0..7 = 1..8 and out_lanes=8.
REQ-033 Early close: feed 5, 6, 7 with in_last on 7 -> lanes = 5,6,7,0,0,0,0,0 and out_lanes=3; downstream pair sums 11, 7, 0, 0.
REQ-034 Backpressure: vector held with out_ready=0 for 10 cycles -> out_data stable, in_ready=0 throughout, no element lost.
REQ-035 Back-to-back: 16 elements 0..15 streamed with out_ready=1 -> two vectors (0..7) then (8..15), in_ready never 0, no bubble cycle.
REQ-036 Single-element vectors: three elements each with in_last=1 and out_ready=1 -> three consecutive 1-lane vectors, out_lanes=1 each.
REQ-037 Reset mid-fill: after 3 of 8 elements, pulse rst_n low asynchronously between edges -> outputs zero immediately; the next 8 elements form a clean vector starting at lane 0.
